multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 162 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction-sequencing controller: FETCH/DECODE/REGRD/EXEC/[MEM]/WB, halting at MAX_PC.
// Latency 5 cycles per instruction, 6 + memory wait for lw; MEM stalls on mem_ready, start is ignored while busy.
module multicycle_ctrl #(
    parameter int MAX_PC = 11,
    parameter int PC_W   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [7:0]      imm,
    input  logic            eq,
    input  logic            dest_zero,
    input  logic            mem_ready,
    output logic [PC_W-1:0] pc,
    output logic            ir_load,
    output logic            dec_en,
    output logic            rf_rd_en,
    output logic            mem_rd,
    output logic            rf_wr_en,
    output logic [1:0]      alu_op,
    output logic            alu_src_imm,
    output logic            busy,
    output logic            done,
    output logic            invalid,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_REGRD  = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t          cur, nxt;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] tgt_q;
    logic            wr_q;
    logic            taken_q;
    logic            inv_q;

    logic            is_addu, is_slt, is_addiu, is_lw, is_beq, is_bne;
    logic            is_write, is_valid, br_taken, start_go;
    logic [PC_W-1:0] off;
    logic [PC_W-1:0] pc_new;

    always_comb begin
        is_addu  = (opcode == 6'h00) && (funct == 6'h21);
        is_slt   = (opcode == 6'h00) && (funct == 6'h2a);
        is_addiu = (opcode == 6'h09);
        is_lw    = (opcode == 6'h23);
        is_beq   = (opcode == 6'h04);
        is_bne   = (opcode == 6'h05);
        is_write = is_addu | is_slt | is_addiu | is_lw;
        is_valid = is_write | is_beq | is_bne;
        br_taken = (is_beq & eq) | (is_bne & ~eq);
        start_go = start && ((cur == S_IDLE) || (cur == S_HALT));
    end

    // Sign-extend (or truncate) the 8-bit offset to the PC width.
    always_comb begin
        off = '0;
        for (int i = 0; i < PC_W; i++) begin
            off[i] = imm[(i < 8) ? i : 7];
        end
    end

    always_comb begin
        pc_new = taken_q ? tgt_q : pc_q + PC_W'(1);
    end

    // Branch outcome, write enable and target are captured in EXEC so WB is independent of later input changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur     <= S_IDLE;
            pc_q    <= '0;
            tgt_q   <= '0;
            wr_q    <= 1'b0;
            taken_q <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            cur <= nxt;
            if (start_go) begin
                pc_q  <= '0;
                inv_q <= 1'b0;
            end
            if (cur == S_EXEC) begin
                wr_q    <= is_write & ~dest_zero;
                taken_q <= br_taken;
                tgt_q   <= pc_q + off;
                if (!is_valid) inv_q <= 1'b1;
            end
            if (cur == S_WB) pc_q <= pc_new;
        end
    end

    always_comb begin
        nxt         = cur;
        ir_load     = 1'b0;
        dec_en      = 1'b0;
        rf_rd_en    = 1'b0;
        mem_rd      = 1'b0;
        rf_wr_en    = 1'b0;
        alu_op      = 2'b10;
        alu_src_imm = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (cur)
            S_IDLE: begin
                if (start) nxt = S_FETCH;
            end
            S_FETCH: begin
                ir_load = 1'b1;
                busy    = 1'b1;
                nxt     = S_DECODE;
            end
            S_DECODE: begin
                dec_en = 1'b1;
                busy   = 1'b1;
                nxt    = S_REGRD;
            end
            S_REGRD: begin
                rf_rd_en = 1'b1;
                busy     = 1'b1;
                nxt      = S_EXEC;
            end
            S_EXEC: begin
                busy = 1'b1;
                if (is_addu || is_addiu || is_lw) alu_op = 2'b00;
                else if (is_slt)                  alu_op = 2'b01;
                alu_src_imm = is_addiu | is_lw;
                nxt = is_lw ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_rd = 1'b1;
                busy   = 1'b1;
                if (mem_ready) nxt = S_WB;
            end
            S_WB: begin
                rf_wr_en = wr_q;
                busy     = 1'b1;
                nxt = ({{(32-PC_W){1'b0}}, pc_new} >= $unsigned(MAX_PC)) ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                done = 1'b1;
                if (start) nxt = S_FETCH;
            end
            default: nxt = S_IDLE;
        endcase
    end

    assign pc      = pc_q;
    assign invalid = inv_q;
    assign state   = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random instruction streams scored against an instruction-level model.
module tb_multicycle_ctrl;
    localparam int MAX_PC = 11;
    localparam int PC_W   = 4;
    localparam int PC_MOD = 1 << PC_W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [5:0]      opcode = '0;
    logic [5:0]      funct = '0;
    logic [7:0]      imm = '0;
    logic            eq = 1'b0;
    logic            dest_zero = 1'b0;
    logic            mem_ready = 1'b0;
    logic [PC_W-1:0] pc;
    logic            ir_load, dec_en, rf_rd_en, mem_rd, rf_wr_en;
    logic [1:0]      alu_op;
    logic            alu_src_imm, busy, done, invalid;
    logic [2:0]      state;

    int n_chk = 0;
    int n_err = 0;
    int m_pc  = 0;
    bit m_inv = 0;

    multicycle_ctrl #(.MAX_PC(MAX_PC), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .funct(funct),
        .imm(imm), .eq(eq), .dest_zero(dest_zero), .mem_ready(mem_ready), .pc(pc),
        .ir_load(ir_load), .dec_en(dec_en), .rf_rd_en(rf_rd_en), .mem_rd(mem_rd),
        .rf_wr_en(rf_wr_en), .alu_op(alu_op), .alu_src_imm(alu_src_imm), .busy(busy),
        .done(done), .invalid(invalid), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {ir_load,dec_en,rf_rd_en,mem_rd,rf_wr_en,busy,done} for a given architectural state.
    function automatic logic [6:0] exp_strobes(input int st, input bit wr);
        return {st == 1, st == 2, st == 3, st == 5, (st == 6) && wr, (st >= 1) && (st <= 6), st == 7};
    endfunction

    task automatic chk_cycle(input string tag, input int st, input bit wr);
        chk({tag, "_state"}, 32'(state), 32'(st));
        chk({tag, "_strobes"}, 32'({ir_load, dec_en, rf_rd_en, mem_rd, rf_wr_en, busy, done}),
            32'(exp_strobes(st, wr)));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_pc  = 0;
        m_inv = 0;
        chk_cycle("reset", 0, 0);
        chk("reset_pc", 32'(pc), 0);
        chk("reset_aluop", 32'({alu_op, alu_src_imm, invalid}), 32'b100_0);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        m_pc  = 0;
        m_inv = 0;
        chk("start_state", 32'(state), 1);
        chk("start_pc", 32'(pc), 0);
        chk("start_flags", 32'({invalid, done}), 0);
    endtask

    // Runs one instruction from FETCH through WB and scores the cycle trace against the instruction model.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [7:0] im,
                             input logic e, input logic dz, input int waits);
        int  seq[$];
        int  off, newpc, exp_aop, mem_k;
        bit  wr, valid, taken, src;
        bit  w_addu, w_slt;
        w_addu = (op == 6'h00) && (fn == 6'h21);
        w_slt  = (op == 6'h00) && (fn == 6'h2a);
        wr     = w_addu || w_slt || op == 6'h09 || op == 6'h23;
        valid  = wr || op == 6'h04 || op == 6'h05;
        taken  = (op == 6'h04 && e) || (op == 6'h05 && !e);
        exp_aop = (w_addu || op == 6'h09 || op == 6'h23) ? 0 : (w_slt ? 1 : 2);
        src    = (op == 6'h09) || (op == 6'h23);
        off    = int'(im);
        if (off >= 128) off -= 256;
        newpc  = taken ? (((m_pc + off) % PC_MOD) + PC_MOD) % PC_MOD : (m_pc + 1) % PC_MOD;
        seq = '{1, 2, 3, 4};
        if (op == 6'h23) for (int k = 0; k <= waits; k++) seq.push_back(5);
        seq.push_back(6);

        opcode = op; funct = fn; imm = im; eq = e; dest_zero = dz; mem_ready = 1'b0;
        chk("fetch_pc", 32'(pc), 32'(m_pc));
        mem_k = 0;
        foreach (seq[i]) begin
            chk_cycle("instr", seq[i], wr && !dz);
            if (seq[i] == 4) chk("exec_alu", 32'({alu_op, alu_src_imm}), 32'({exp_aop[1:0], src}));
            if (seq[i] == 5) begin
                mem_k++;
                mem_ready = (mem_k > waits);
            end else begin
                mem_ready = 1'b0;
            end
            step();
        end
        mem_ready = 1'b0;
        if (!valid) m_inv = 1;
        m_pc = newpc;
        chk("wb_pc", 32'(pc), 32'(m_pc));
        chk("wb_invalid", 32'(invalid), 32'(m_inv));
        chk_cycle("after_wb", (m_pc >= MAX_PC) ? 7 : 1, 0);
    endtask

    task automatic run_random();
        int sel;
        logic [5:0] op, fn;
        sel = $urandom_range(0, 7);
        fn  = 6'($urandom_range(0, 63));
        op  = 6'h00;
        case (sel)
            0: fn = 6'h21;
            1: fn = 6'h2a;
            2: if (fn == 6'h21 || fn == 6'h2a) fn = 6'h00;
            3: op = 6'h09;
            4: op = 6'h23;
            5: op = 6'h04;
            6: op = 6'h05;
            default: begin
                op = 6'($urandom_range(10, 63));
                if (op == 6'h23) op = 6'h3f;
            end
        endcase
        run_instr(op, fn, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3));
    endtask

    initial begin
        rst_n = 1'b0;
        step();
        do_reset();
        step();
        chk_cycle("idle_hold", 0, 0);

        // addiu, lw with three wait cycles, then branches up to the halt boundary.
        do_start();
        run_instr(6'h09, 6'h00, 8'h00, 1'b0, 1'b0, 0);
        run_instr(6'h23, 6'h00, 8'h00, 1'b0, 1'b0, 3);
        run_instr(6'h04, 6'h00, 8'h04, 1'b1, 1'b0, 0);
        run_instr(6'h04, 6'h00, 8'h05, 1'b1, 1'b0, 0);
        chk("halt_pc", 32'(pc), 11);
        step();
        chk_cycle("halt_hold", 7, 0);

        // bne backward branch, invalid opcode stickiness, addu to $0.
        do_start();
        run_instr(6'h05, 6'h00, 8'h0a, 1'b0, 1'b0, 0);
        run_instr(6'h05, 6'h00, 8'hfd, 1'b0, 1'b0, 0);
        chk("bne_back_pc", 32'(pc), 7);
        run_instr(6'h3f, 6'h00, 8'h00, 1'b0, 1'b0, 0);
        run_instr(6'h00, 6'h21, 8'h00, 1'b0, 1'b1, 0);
        run_instr(6'h00, 6'h2a, 8'h00, 1'b0, 1'b0, 0);
        run_instr(6'h09, 6'h00, 8'h00, 1'b0, 1'b0, 0);
        chk("sticky_invalid", 32'(invalid), 1);
        do_start();
        chk("invalid_cleared", 32'(invalid), 0);

        // Reset in the middle of a MEM wait aborts without a write.
        opcode = 6'h23; funct = 6'h00; dest_zero = 1'b0; mem_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (rf_wr_en) chk("abort_no_wr", 32'(rf_wr_en), 0);
            step();
        end
        chk("abort_in_mem", 32'(state), 5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_state", 32'(state), 0);
        chk("abort_pc", 32'(pc), 0);
        chk("abort_wr", 32'(rf_wr_en), 0);
        step();
        chk_cycle("abort_idle", 0, 0);
        m_pc = 0; m_inv = 0;

        // Random instruction streams; an unfinished stream is ended with a reset.
        for (int r = 0; r < 20; r++) begin
            do_start();
            for (int k = 0; k < 12 && m_pc < MAX_PC; k++) run_random();
            if (m_pc < MAX_PC) begin
                start = 1'b1;
                step();
                start = 1'b0;
                chk("ignore_start", 32'(state), 2);
                do_reset();
            end else begin
                chk("rand_done", 32'({done, busy}), 32'b10);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
